// File: rtl/timer_tick_sequencer.sv
// timer_tick_sequencer: Avalon-MM master that programs, services, stops and snapshots
// a 16-bit-register interval timer; all bus and status outputs are registered.
module timer_tick_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_start,
    input  logic [31:0]      cfg_period,
    input  logic             cfg_continuous,
    input  logic             stop_req,
    input  logic             snap_req,
    output logic [2:0]       tmr_address,
    output logic             tmr_chipselect,
    output logic             tmr_write_n,
    output logic [15:0]      tmr_writedata,
    input  logic [15:0]      tmr_readdata,
    input  logic             tmr_irq,
    output logic             busy,
    output logic             running,
    output logic             tick,
    output logic [CNT_W-1:0] tick_count,
    output logic [31:0]      snap_value,
    output logic             snap_valid,
    output logic             cfg_err
);
    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_CTRL, RUN, CLR_ST, STOP_WR, STOP_CLR,
        SNAP_WR, SNAP_RL, SNAP_RH, SNAP_FIN
    } state_t;

    state_t      r_state, w_next;
    logic [31:0] r_period;
    logic        r_cont;
    logic        w_take, w_accept, w_reject;

    // cfg_start is only considered in IDLE, or in RUN when no IRQ outranks it
    assign w_take   = cfg_start && (r_state == IDLE || (r_state == RUN && !tmr_irq));
    assign w_accept = w_take && cfg_period != 32'd0;
    assign w_reject = w_take && cfg_period == 32'd0;

    always_comb begin
        w_next = IDLE;
        case (r_state)
            IDLE:     w_next = w_accept ? WR_PL : IDLE;
            WR_PL:    w_next = WR_PH;
            WR_PH:    w_next = WR_CTRL;
            WR_CTRL:  w_next = RUN;
            RUN:      w_next = tmr_irq ? CLR_ST : w_accept ? WR_PL : w_take ? RUN :
                               stop_req ? STOP_WR : snap_req ? SNAP_WR : RUN;
            CLR_ST:   w_next = r_cont ? RUN : IDLE;
            STOP_WR:  w_next = STOP_CLR;
            STOP_CLR: w_next = IDLE;
            SNAP_WR:  w_next = SNAP_RL;
            SNAP_RL:  w_next = SNAP_RH;
            SNAP_RH:  w_next = SNAP_FIN;
            SNAP_FIN: w_next = RUN;
            default:  w_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the state they belong to
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state        <= IDLE;
            r_period       <= 32'd0;
            r_cont         <= 1'b0;
            tmr_address    <= 3'd0;
            tmr_chipselect <= 1'b0;
            tmr_write_n    <= 1'b1;
            tmr_writedata  <= 16'd0;
            busy           <= 1'b0;
            running        <= 1'b0;
            tick           <= 1'b0;
            tick_count     <= '0;
            snap_value     <= 32'd0;
            snap_valid     <= 1'b0;
            cfg_err        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_period <= cfg_period;
                r_cont   <= cfg_continuous;
            end
            tmr_chipselect <= !(w_next inside {IDLE, RUN, SNAP_FIN});
            tmr_write_n    <= !(w_next inside {WR_PL, WR_PH, WR_CTRL, CLR_ST, STOP_WR, STOP_CLR, SNAP_WR});
            tmr_address    <= (w_next == WR_PL) ? 3'd2 :
                              (w_next == WR_PH) ? 3'd3 :
                              (w_next inside {WR_CTRL, STOP_WR}) ? 3'd1 :
                              (w_next inside {SNAP_WR, SNAP_RL}) ? 3'd4 :
                              (w_next == SNAP_RH) ? 3'd5 : 3'd0;
            tmr_writedata  <= (w_next == WR_PL) ? cfg_period[15:0] :
                              (w_next == WR_PH) ? r_period[31:16] :
                              (w_next == WR_CTRL) ? (16'h0005 | {14'd0, r_cont, 1'b0}) :
                              (w_next == STOP_WR) ? 16'h0008 : 16'h0000;
            busy       <= !(w_next inside {IDLE, RUN});
            running    <= !(w_next inside {IDLE, WR_PL, WR_PH, WR_CTRL});
            tick       <= w_next == CLR_ST;
            tick_count <= w_accept ? '0 : (w_next == CLR_ST) ? tick_count + CNT_W'(1) : tick_count;
            cfg_err    <= w_reject;
            if (r_state == SNAP_RH)
                snap_value[15:0] <= tmr_readdata;
            if (r_state == SNAP_FIN)
                snap_value[31:16] <= tmr_readdata;
            snap_valid <= r_state == SNAP_FIN;
        end
    end
endmodule

// File: tb/tb_timer_tick_sequencer.sv
// tb_timer_tick_sequencer: directed bench with a small timer slave model (registered
// readdata, level IRQ cleared by a status write); a CNT_W=2 twin exercises counter wrap.
module tb_timer_tick_sequencer;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cfg_start, cfg_continuous, stop_req, snap_req;
    logic [31:0] cfg_period;
    logic [2:0]  tmr_address;
    logic        tmr_chipselect, tmr_write_n;
    logic [15:0] tmr_writedata;
    logic [15:0] rd;
    logic        irq, irq_pulse;
    logic        busy, running, tick, snap_valid, cfg_err;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  addr_s;
    logic        cs_s, wn_s, busy_s, running_s, tick_s, sv_s, err_s;
    logic [15:0] wd_s;
    logic [1:0]  tc_s;
    logic [31:0] snap_s;
    logic [20:0] bus;
    int          pass_cnt = 0;
    int          total = 0;

    always #5 clk = ~clk;
    assign bus = {tmr_chipselect, tmr_write_n, tmr_address, tmr_writedata};

    timer_tick_sequencer #(.CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .tmr_address(tmr_address), .tmr_chipselect(tmr_chipselect), .tmr_write_n(tmr_write_n),
        .tmr_writedata(tmr_writedata), .tmr_readdata(rd), .tmr_irq(irq), .busy(busy),
        .running(running), .tick(tick), .tick_count(tick_count), .snap_value(snap_value),
        .snap_valid(snap_valid), .cfg_err(cfg_err));

    timer_tick_sequencer #(.CNT_W(2)) u_small (
        .clk(clk), .reset_n(reset_n), .cfg_start(cfg_start), .cfg_period(cfg_period),
        .cfg_continuous(cfg_continuous), .stop_req(stop_req), .snap_req(snap_req),
        .tmr_address(addr_s), .tmr_chipselect(cs_s), .tmr_write_n(wn_s),
        .tmr_writedata(wd_s), .tmr_readdata(rd), .tmr_irq(irq), .busy(busy_s),
        .running(running_s), .tick(tick_s), .tick_count(tc_s), .snap_value(snap_s),
        .snap_valid(sv_s), .cfg_err(err_s));

    always_ff @(posedge clk) begin
        rd  <= (tmr_address == 3'd5) ? 16'h00AB : (tmr_address == 3'd4) ? 16'h1234 : 16'h0000;
        irq <= reset_n && (irq || irq_pulse) && !(tmr_chipselect && !tmr_write_n && tmr_address == 3'd0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fire_irq();
        irq_pulse = 1'b1;
        step();
        irq_pulse = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; cfg_start = 0; cfg_period = 0; cfg_continuous = 0;
        stop_req = 0; snap_req = 0; irq_pulse = 0;
        step(); step();
        total++; if (bus !== {2'b01, 3'd0, 16'h0}) $display("FAIL reset_bus got %h exp %h", bus, {2'b01, 3'd0, 16'h0}); else pass_cnt++;
        total++; if ({busy, running, tick, snap_valid, cfg_err} !== 5'b0) $display("FAIL reset_flags got %b exp 00000", {busy, running, tick, snap_valid, cfg_err}); else pass_cnt++;
        total++; if (tick_count !== 16'd0 || snap_value !== 32'd0) $display("FAIL reset_regs got %h/%h exp 0/0", tick_count, snap_value); else pass_cnt++;
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_start();
        cfg_start = 1; cfg_period = 32'h0001_0002; cfg_continuous = 1;
        step();
        cfg_start = 0;
        total++; if (bus !== {2'b10, 3'd2, 16'h0002}) $display("FAIL start_pl got %h exp %h", bus, {2'b10, 3'd2, 16'h0002}); else pass_cnt++;
        total++; if (busy !== 1'b1) $display("FAIL start_busy got %b exp 1", busy); else pass_cnt++;
        step();
        total++; if (bus !== {2'b10, 3'd3, 16'h0001}) $display("FAIL start_ph got %h exp %h", bus, {2'b10, 3'd3, 16'h0001}); else pass_cnt++;
        step();
        total++; if (bus !== {2'b10, 3'd1, 16'h0007}) $display("FAIL start_ctrl got %h exp %h", bus, {2'b10, 3'd1, 16'h0007}); else pass_cnt++;
        step();
        total++; if ({bus, running, busy} !== {2'b01, 3'd0, 16'h0, 2'b10}) $display("FAIL start_run got %h/%b%b exp idle bus, running=1 busy=0", bus, running, busy); else pass_cnt++;
    endtask

    task automatic test_ticks();
        int pulses = 0;
        for (int i = 0; i < 4; i++) begin
            fire_irq();
            step();
            total++; if (bus !== {2'b10, 3'd0, 16'h0}) $display("FAIL tick_clr%0d got %h exp %h", i, bus, {2'b10, 3'd0, 16'h0}); else pass_cnt++;
            pulses += int'(tick);
            step();
            pulses += int'(tick);
            if (i == 2) begin
                total++; if (tick_count !== 16'd3 || pulses != 3) $display("FAIL tick_three got cnt %0d pulses %0d exp 3/3", tick_count, pulses); else pass_cnt++;
            end
        end
        total++; if (tick_count !== 16'd4 || running !== 1'b1) $display("FAIL tick_four got cnt %0d run %b exp 4/1", tick_count, running); else pass_cnt++;
        total++; if (tc_s !== 2'd0) $display("FAIL tick_wrap got %0d exp 0", tc_s); else pass_cnt++;
    endtask

    task automatic test_snapshot();
        int n = 1;
        snap_req = 1;
        step();
        snap_req = 0;
        total++; if (bus !== {2'b10, 3'd4, 16'h0}) $display("FAIL snap_wr got %h exp %h", bus, {2'b10, 3'd4, 16'h0}); else pass_cnt++;
        step(); n++;
        total++; if (bus !== {2'b11, 3'd4, 16'h0}) $display("FAIL snap_rl got %h exp %h", bus, {2'b11, 3'd4, 16'h0}); else pass_cnt++;
        step(); n++;
        total++; if (bus !== {2'b11, 3'd5, 16'h0}) $display("FAIL snap_rh got %h exp %h", bus, {2'b11, 3'd5, 16'h0}); else pass_cnt++;
        while (!snap_valid && n < 8) begin
            step(); n++;
        end
        total++; if (snap_valid !== 1'b1 || n < 4 || n > 5) $display("FAIL snap_latency got valid %b after %0d cycles exp valid within 4..5", snap_valid, n); else pass_cnt++;
        total++; if (snap_value !== 32'h00AB_1234) $display("FAIL snap_value got %h exp 00ab1234", snap_value); else pass_cnt++;
        step();
        total++; if ({snap_valid, busy, running} !== 3'b001) $display("FAIL snap_after got %b exp 001", {snap_valid, busy, running}); else pass_cnt++;
    endtask

    task automatic test_priority();
        logic seen = 1'b0;
        fire_irq();
        stop_req = 1; snap_req = 1;
        step();
        stop_req = 0; snap_req = 0;
        total++; if ({bus, tick} !== {2'b10, 3'd0, 16'h0, 1'b1}) $display("FAIL prio_clr got %h/%b exp %h/1", bus, tick, {2'b10, 3'd0, 16'h0}); else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            step();
            seen |= tmr_chipselect | snap_valid | !running;
        end
        total++; if (seen !== 1'b0) $display("FAIL prio_dropped got activity %b exp 0", seen); else pass_cnt++;
        cfg_start = 1; cfg_period = 32'd0;
        step();
        cfg_start = 0;
        total++; if ({cfg_err, tmr_chipselect, running} !== 3'b101) $display("FAIL prio_err got %b exp 101", {cfg_err, tmr_chipselect, running}); else pass_cnt++;
        step();
        total++; if ({cfg_err, tmr_chipselect} !== 2'b00) $display("FAIL prio_err_pulse got %b exp 00", {cfg_err, tmr_chipselect}); else pass_cnt++;
    endtask

    task automatic test_stop();
        stop_req = 1;
        step();
        stop_req = 0;
        total++; if (bus !== {2'b10, 3'd1, 16'h0008}) $display("FAIL stop_wr got %h exp %h", bus, {2'b10, 3'd1, 16'h0008}); else pass_cnt++;
        step();
        total++; if ({bus, tick} !== {2'b10, 3'd0, 16'h0, 1'b0}) $display("FAIL stop_clr got %h/%b exp %h/0", bus, tick, {2'b10, 3'd0, 16'h0}); else pass_cnt++;
        step();
        total++; if ({busy, running, tmr_chipselect, tick_count} !== {3'b000, 16'd5}) $display("FAIL stop_idle got %b cnt %0d exp 000 cnt 5", {busy, running, tmr_chipselect}, tick_count); else pass_cnt++;
    endtask

    task automatic test_oneshot();
        cfg_start = 1; cfg_period = 32'd5; cfg_continuous = 0;
        step();
        cfg_start = 0;
        total++; if ({bus, tick_count} !== {2'b10, 3'd2, 16'h0005, 16'd0}) $display("FAIL os_pl got %h cnt %0d exp %h cnt 0", bus, tick_count, {2'b10, 3'd2, 16'h0005}); else pass_cnt++;
        step(); step();
        total++; if (bus !== {2'b10, 3'd1, 16'h0005}) $display("FAIL os_ctrl got %h exp %h", bus, {2'b10, 3'd1, 16'h0005}); else pass_cnt++;
        step();
        fire_irq();
        step();
        total++; if ({bus, tick} !== {2'b10, 3'd0, 16'h0, 1'b1}) $display("FAIL os_clr got %h/%b exp %h/1", bus, tick, {2'b10, 3'd0, 16'h0}); else pass_cnt++;
        step();
        total++; if ({running, busy, tick_count} !== {2'b00, 16'd1}) $display("FAIL os_idle got %b%b cnt %0d exp 00 cnt 1", running, busy, tick_count); else pass_cnt++;
        stop_req = 1; snap_req = 1;
        step();
        stop_req = 0; snap_req = 0;
        step();
        total++; if ({tmr_chipselect, busy, snap_valid} !== 3'b000) $display("FAIL os_ignore got %b exp 000", {tmr_chipselect, busy, snap_valid}); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        cfg_start = 1; cfg_period = 32'h0003_0004; cfg_continuous = 1;
        step();
        cfg_start = 0;
        step();
        total++; if (bus !== {2'b10, 3'd3, 16'h0003}) $display("FAIL rst_ph got %h exp %h", bus, {2'b10, 3'd3, 16'h0003}); else pass_cnt++;
        #2 reset_n = 1'b0;
        #1;
        total++; if ({tmr_chipselect, tmr_write_n} !== 2'b01) $display("FAIL rst_async got %b exp 01", {tmr_chipselect, tmr_write_n}); else pass_cnt++;
        step();
        reset_n = 1'b1;
        step(); step();
        total++; if ({busy, running, tmr_chipselect, tick_count} !== {3'b000, 16'd0}) $display("FAIL rst_idle got %b cnt %0d exp 000 cnt 0", {busy, running, tmr_chipselect}, tick_count); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_start();
        test_ticks();
        test_snapshot();
        test_priority();
        test_stop();
        test_oneshot();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
